reg_bank_wb: RTL and testbench

//  Register bank that receives the write-back word selected by the write-back source mux.

---
 rtl/reg_bank_wb.sv | 105 ++++++++++
 tb/tb_reg_bank_wb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_wb.sv
// Write-back register bank: one handshaked write port feeding a one-entry pending buffer,
// two combinational read ports that forward from the buffer.
module reg_bank_wb #(
  parameter int              NREGS       = 32,
  parameter int              AW          = 5,
  parameter int              DW          = 32,
  parameter int              STACK_REG   = 29,
  parameter logic [DW-1:0]   STACK_START = 32'd227,
  parameter bit              BYPASS      = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          stall,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic          pend_valid
);

  logic          pend_valid_q, pend_valid_d;
  logic [AW-1:0] pend_addr_q,  pend_addr_d;
  logic [DW-1:0] pend_data_q,  pend_data_d;
  logic [DW-1:0] regs_q [NREGS];

  logic accept;
  logic drain;
  logic take;

  assign wb_ready   = !pend_valid_q || !stall;
  assign accept     = wb_valid && wb_ready;
  assign drain      = pend_valid_q && !stall;
  // Writes to r0 are consumed by the handshake but never enter the buffer.
  assign take       = accept && (wb_addr != '0);
  assign pend_valid = pend_valid_q;

  always_comb begin
    pend_valid_d = pend_valid_q && !drain;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    if (take) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = wb_addr;
      pend_data_d  = wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
    end
  end

  // Each architectural register is its own flop bank so it can carry an async reset value.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs_q[gi] = '0;
      end else begin : g_flop
        localparam logic [DW-1:0] RST_VAL = (gi == STACK_REG) ? STACK_START : '0;
        logic [DW-1:0] r_q;
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_q <= RST_VAL;
          end else if (drain && (pend_addr_q == AW'(gi))) begin
            r_q <= pend_data_q;
          end
        end
        assign regs_q[gi] = r_q;
      end
    end
  endgenerate

  always_comb begin
    rs_data = regs_q[rs_addr];
    if (BYPASS && pend_valid_q && (pend_addr_q == rs_addr)) begin
      rs_data = pend_data_q;
    end
    if (rs_addr == '0) begin
      rs_data = '0;
    end
  end

  always_comb begin
    rt_data = regs_q[rt_addr];
    if (BYPASS && pend_valid_q && (pend_addr_q == rt_addr)) begin
      rt_data = pend_data_q;
    end
    if (rt_addr == '0) begin
      rt_data = '0;
    end
  end

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed bench for reg_bank_wb: expectations are queued as stimulus is driven and
// popped when the corresponding output is observed.
module tb_reg_bank_wb;

  logic        clk;
  logic        reset_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        pend_valid;

  int vectors;
  int miscompares;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  reg_bank_wb dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .stall      (stall),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .pend_valid (pend_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!wb_ready && n < budget) begin
      step();
      n++;
    end
    vectors++;
    assert (wb_ready === 1'b1) else begin
      miscompares++;
      $error("FAIL wait_ready observed=%b expected=1 after %0d cycles", wb_ready, n);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n  = 1'b0;
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    stall    = 1'b0;
    rs_addr  = '0;
    rt_addr  = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: reset state
    rs_addr = 5'd29; rt_addr = 5'd5;
    #1;
    sb_push("rst_sp", 32'd227);        sb_check(rs_data);
    sb_push("rst_r5", 32'd0);          sb_check(rt_data);
    sb_push("rst_pend", 32'd0);        sb_check(32'(pend_valid));
    sb_push("rst_ready", 32'd1);       sb_check(32'(wb_ready));

    // 2: simple write with bypass, then commit
    wb_valid = 1'b1; wb_addr = 5'd8; wb_data = 32'hDEADBEEF; rs_addr = 5'd8;
    sb_push("w8_bypass", 32'hDEADBEEF);
    sb_push("w8_pend", 32'd1);
    step();
    wb_valid = 1'b0;
    sb_check(rs_data);
    sb_check(32'(pend_valid));
    sb_push("w8_array", 32'hDEADBEEF);
    sb_push("w8_pend_clr", 32'd0);
    step();
    sb_check(rs_data);
    sb_check(32'(pend_valid));

    // 3: stall with full buffer, then release
    stall = 1'b1; wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
    #1;
    sb_push("st_ready_empty", 32'd1);  sb_check(32'(wb_ready));
    step();
    wb_addr = 5'd4; wb_data = 32'h22; rs_addr = 5'd3; rt_addr = 5'd4;
    #1;
    sb_push("st_ready_full", 32'd0);   sb_check(32'(wb_ready));
    step();
    sb_push("st_r3_bypass", 32'h11);   sb_check(rs_data);
    sb_push("st_r4_held", 32'h0);      sb_check(rt_data);
    sb_push("st_pend", 32'd1);         sb_check(32'(pend_valid));
    stall = 1'b0;
    #1;
    wait_ready(8);
    step();
    wb_valid = 1'b0;
    sb_push("st_r3_array", 32'h11);    sb_check(rs_data);
    sb_push("st_r4_bypass", 32'h22);   sb_check(rt_data);
    step();
    sb_push("st_r4_array", 32'h22);    sb_check(rt_data);
    sb_push("st_pend_clr", 32'd0);     sb_check(32'(pend_valid));

    // 4: write to r0 is dropped
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF; rs_addr = 5'd0; rt_addr = 5'd8;
    step();
    wb_valid = 1'b0;
    sb_push("r0_pend", 32'd0);         sb_check(32'(pend_valid));
    sb_push("r0_read", 32'd0);         sb_check(rs_data);
    sb_push("r8_keep", 32'hDEADBEEF);  sb_check(rt_data);

    // 5: back-to-back writes to r1
    rs_addr = 5'd1;
    for (int k = 1; k <= 3; k++) begin
      wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'(k);
      sb_push($sformatf("b2b_r1_%0d", k), 32'(k));
      step();
      sb_check(rs_data);
    end
    wb_valid = 1'b0;
    step();
    sb_push("b2b_pend_clr", 32'd0);    sb_check(32'(pend_valid));
    sb_push("b2b_array", 32'd3);       sb_check(rs_data);

    // 6: reset while a write is held pending
    stall = 1'b1; wb_valid = 1'b1; wb_addr = 5'd29; wb_data = 32'h100; rs_addr = 5'd29;
    step();
    wb_valid = 1'b0;
    sb_push("rr_bypass", 32'h100);     sb_check(rs_data);
    #2 reset_n = 1'b0;
    #1;
    sb_push("rr_pend_async", 32'd0);   sb_check(32'(pend_valid));
    sb_push("rr_sp_async", 32'd227);   sb_check(rs_data);
    #3 reset_n = 1'b1;
    stall = 1'b0;
    step();
    step();
    sb_push("rr_sp_final", 32'd227);   sb_check(rs_data);
    sb_push("rr_pend_final", 32'd0);   sb_check(32'(pend_valid));
    rt_addr = 5'd8;
    #1;
    sb_push("rr_r8_cleared", 32'd0);   sb_check(rt_data);

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
